// File: rtl/bin2bcd_seq.sv
// Purpose: sequential 7-bit binary to 2-digit BCD converter (shift-add-3, one bit per clock).
// Latency: 8 clocks from the accepting edge to valid msd/lsd/ovf; one conversion per 9 clocks.
// Backpressure: none queued; start is sampled only in IDLE and ignored while a conversion runs.
//
// Ports:
//   clk   - rising-edge clock for all state
//   rst   - synchronous, active-high reset
//   start - conversion request, sampled only in IDLE
//   bin   - 7-bit binary operand, captured on the accepting edge
//   busy  - high from the edge after acceptance until the done pulse ends
//   done  - one-cycle pulse when msd/lsd/ovf update
//   msd   - tens BCD digit (registered, holds between conversions)
//   lsd   - units BCD digit (registered, holds between conversions)
//   ovf   - registered; high when the captured operand exceeded 99
//
// Build option: define BIN2BCD_SATURATE_EN to force msd = lsd = 9 whenever ovf = 1;
// otherwise the digits carry the true value mod 100.

module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] msd,
  output logic [3:0] lsd,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] sr;         // operand, consumed MSB first
  logic [8:0] acc;        // {hundreds[0], tens[3:0], units[3:0]}
  logic [2:0] cnt;

  logic [3:0] tens_adj, units_adj;
  logic       ovf_calc;
  logic [3:0] msd_calc, lsd_calc;

  // add-3 correction applied before each shift so a digit >= 5 carries out cleanly
  assign units_adj = (acc[3:0] >= 4'd5) ? acc[3:0] + 4'd3 : acc[3:0];
  assign tens_adj  = (acc[7:4] >= 4'd5) ? acc[7:4] + 4'd3 : acc[7:4];

  assign ovf_calc = acc[8] | (acc[7:4] >= 4'd10);

`ifdef BIN2BCD_SATURATE_EN
  assign msd_calc = ovf_calc ? 4'd9 : acc[7:4];
  assign lsd_calc = ovf_calc ? 4'd9 : acc[3:0];
`else
  // the hundreds bit is simply dropped, leaving value mod 100
  assign msd_calc = acc[7:4];
  assign lsd_calc = acc[3:0];
`endif

  // the done cycle counts as busy so that busy spans the whole 8-clock latency;
  // state is already back in IDLE then, letting a held start re-accept at N+9
  assign busy = (state != IDLE) || done;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == 3'd6) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      msd   <= '0;
      lsd   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr  <= bin;
            acc <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          // {acc, sr} << 1 on the corrected digits; the old hundreds bit is
          // always 0 here because it can only become set on the final shift
          acc <= {tens_adj, units_adj, sr[6]};
          sr  <= {sr[5:0], 1'b0};
          cnt <= cnt + 3'd1;
        end
        DONE: begin
          msd  <= msd_calc;
          lsd  <= lsd_calc;
          ovf  <= ovf_calc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] bin;
  logic       busy;
  logic       done;
  logic [3:0] msd;
  logic [3:0] lsd;
  logic       ovf;

  bin2bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .msd   (msd),
    .lsd   (lsd),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int       v;
    int       m;
    int       l;
    int       o;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference: decimal arithmetic straight from the definition of the output
  task automatic model(input int v, output int m, output int l, output int o);
    int r;
    o = (v > 99) ? 1 : 0;
    r = v % 100;
    m = r / 10;
    l = r % 10;
`ifdef BIN2BCD_SATURATE_EN
    if (o == 1) begin
      m = 9;
      l = 9;
    end
`endif
  endtask

  // start a conversion on the next edge, then watch 12 edges for the outcome
  task automatic run_conv(input int v, output int lat, output int npulse, output int nbusy,
                          output int m, output int l, output int o);
    start = 1'b1;
    bin   = 7'(v);
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 7'($urandom);
    lat = -1; npulse = 0; nbusy = 0; m = -1; l = -1; o = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (busy) nbusy++;
      if (done) begin
        npulse++;
        if (lat < 0) begin
          lat = i; m = msd; l = lsd; o = ovf;
        end
      end
    end
  endtask

  vec_t vecs[$];
  int lat, np, nb, m, l, o, em, el, eo;
  int pulses[$];

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_msd", msd, 0);
    chk("reset_lsd", lsd, 0);
    chk("reset_ovf", ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed table
    vecs.push_back('{57, 5, 7, 0});
    vecs.push_back('{0, 0, 0, 0});
    vecs.push_back('{99, 9, 9, 0});
    vecs.push_back('{9, 0, 9, 0});
    vecs.push_back('{10, 1, 0, 0});
    vecs.push_back('{64, 6, 4, 0});
`ifdef BIN2BCD_SATURATE_EN
    vecs.push_back('{127, 9, 9, 1});
    vecs.push_back('{100, 9, 9, 1});
`else
    vecs.push_back('{127, 2, 7, 1});
    vecs.push_back('{100, 0, 0, 1});
`endif
    foreach (vecs[k]) begin
      run_conv(vecs[k].v, lat, np, nb, m, l, o);
      chk($sformatf("tbl%0d_latency", vecs[k].v), lat, 8);
      chk($sformatf("tbl%0d_pulses", vecs[k].v), np, 1);
      chk($sformatf("tbl%0d_busycycles", vecs[k].v), nb, 8);
      chk($sformatf("tbl%0d_msd", vecs[k].v), m, vecs[k].m);
      chk($sformatf("tbl%0d_lsd", vecs[k].v), l, vecs[k].l);
      chk($sformatf("tbl%0d_ovf", vecs[k].v), o, vecs[k].o);
    end

    // full nominal sweep
    for (int v = 0; v <= 99; v++) begin
      run_conv(v, lat, np, nb, m, l, o);
      chk($sformatf("sweep%0d_value", v), m * 10 + l, v);
      chk($sformatf("sweep%0d_ovf", v), o, 0);
    end

    // random operands against the model
    for (int k = 0; k < 40; k++) begin
      int v;
      v = int'($urandom_range(127, 0));
      model(v, em, el, eo);
      run_conv(v, lat, np, nb, m, l, o);
      chk($sformatf("rnd%0d_msd", v), m, em);
      chk($sformatf("rnd%0d_lsd", v), l, el);
      chk($sformatf("rnd%0d_ovf", v), o, eo);
      chk($sformatf("rnd%0d_latency", v), lat, 8);
    end

    // start pulsed during N+2..N+5 must be ignored
    start = 1'b1; bin = 7'd42;
    @(posedge clk); #1;              // edge N
    start = 1'b0; bin = 7'd0;
    np = 0; m = -1; l = -1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;            // edge N+i
      if (i == 1) begin start = 1'b1; bin = 7'd13; end
      if (i == 5) begin start = 1'b0; end
      if (done) begin np++; m = msd; l = lsd; end
    end
    chk("ignore_pulses", np, 1);
    chk("ignore_msd", m, 4);
    chk("ignore_lsd", l, 2);
    chk("ignore_idle_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_msd", msd, 4);
    chk("hold_lsd", lsd, 2);

    // reset during a conversion aborts it with no done pulse
    start = 1'b1; bin = 7'd88;
    @(posedge clk); #1;              // edge N
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;              // edge N+4
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_msd", msd, 0);
    chk("abort_lsd", lsd, 0);
    chk("abort_ovf", ovf, 0);
    np = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) np++;
    end
    chk("abort_no_done", np, 0);
    run_conv(88, lat, np, nb, m, l, o);
    chk("after_abort_msd", m, 8);
    chk("after_abort_lsd", l, 8);
    chk("after_abort_latency", lat, 8);

    // rst and start on the same edge: start is lost
    rst = 1'b1; start = 1'b1; bin = 7'd77;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_vs_start_busy", busy, 0);
    np = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) np++;
    end
    chk("rst_vs_start_no_done", np, 0);

    // held start re-accepts every 9 clocks
    start = 1'b1; bin = 7'd35;
    @(posedge clk); #1;              // edge N (first acceptance)
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses.push_back(i);
        chk($sformatf("held%0d_msd", i), msd, 3);
        chk($sformatf("held%0d_lsd", i), lsd, 5);
      end
    end
    start = 1'b0;
    chk("held_pulse_count", pulses.size(), 4);
    for (int k = 0; k < pulses.size(); k++)
      chk($sformatf("held_pulse%0d_edge", k), pulses[k], 8 + 9 * k);
    repeat (12) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
